// File: rtl/cmul_sched.sv
// cmul_sched -- complex twiddle multiply sequencer, y = x * w.
//
// Time-shares one external real multiplier across the four partial products
// of a complex multiply, one product per cycle:
//   y_re = xr*wr - xi*wi
//   y_im = xr*wi + xi*wr
// The unity twiddle (1.0 + j0) skips the multiplier and forwards x directly.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid and the payload stable until that
// edge. in_ready_o is high only in IDLE. out_valid_o is high only in OUT, and
// y is held stable there until out_ready_i is seen.
//
// Optional feature: define CMUL_SAT_EN to saturate the combined sums to the
// OUT_W range. Without it, the sums wrap in two's complement.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid_i, in_ready_o  operand handshake
//   x_re_i, x_im_i          complex input sample (signed, FRAC fractional bits)
//   w_re_i, w_im_i          complex twiddle (signed, FRAC fractional bits)
//   mul_a_o, mul_b_o        operands to the shared multiplier (0 when idle)
//   mul_p_i                 combinational, already-scaled product of mul_a*mul_b
//   out_valid_o, out_ready_i result handshake
//   y_re_o, y_im_o          result
//   busy_o                  high in any state other than IDLE
//   state_o                 current FSM state, for debug and checkers
module cmul_sched #(
   parameter int IN_W  = 16,
   parameter int FRAC  = 10,
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic signed [IN_W-1:0]  x_re_i,
   input  logic signed [IN_W-1:0]  x_im_i,
   input  logic signed [IN_W-1:0]  w_re_i,
   input  logic signed [IN_W-1:0]  w_im_i,
   output logic signed [IN_W-1:0]  mul_a_o,
   output logic signed [IN_W-1:0]  mul_b_o,
   input  logic signed [OUT_W-1:0] mul_p_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [OUT_W-1:0] y_re_o,
   output logic signed [OUT_W-1:0] y_im_o,
   output logic                    busy_o,
   output logic [2:0]              state_o
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_P0   = 3'd1;
   localparam logic [2:0] S_P1   = 3'd2;
   localparam logic [2:0] S_P2   = 3'd3;
   localparam logic [2:0] S_P3   = 3'd4;
   localparam logic [2:0] S_OUT  = 3'd5;

   localparam logic [IN_W-1:0] W_ONE = IN_W'(64'd1 << FRAC);

   logic [2:0]       state_q, state_d;
   logic [IN_W-1:0]  xr_q, xr_d, xi_q, xi_d, wr_q, wr_d, wi_q, wi_d;
   logic [OUT_W-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
   logic [OUT_W-1:0] y_re_q, y_re_d, y_im_q, y_im_d;
   logic [OUT_W:0]   sum_re, sum_im;
   logic             unused_bits;

   // Sign-extend or truncate an input-format value to the output width.
   function automatic logic [OUT_W-1:0] fit_out(input logic [IN_W-1:0] v);
      logic [IN_W+OUT_W-1:0] wide;
      wide = {{OUT_W{v[IN_W-1]}}, v};
      return wide[OUT_W-1:0];
   endfunction

`ifdef CMUL_SAT_EN
   // The two top bits of the one-bit-wider sum differ only on overflow.
   function automatic logic [OUT_W-1:0] reduce(input logic [OUT_W:0] s);
      if (s[OUT_W] != s[OUT_W-1])
         return s[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      return s[OUT_W-1:0];
   endfunction
`endif

   // p3 is never stored before use: the imaginary sum takes it live in P3.
   assign sum_re = {p0_q[OUT_W-1], p0_q} - {p1_q[OUT_W-1], p1_q};
   assign sum_im = {p2_q[OUT_W-1], p2_q} + {mul_p_i[OUT_W-1], mul_p_i};

   assign unused_bits = ^{sum_re[OUT_W], sum_im[OUT_W], p3_q};

   always_comb begin
      state_d = state_q;
      xr_d    = xr_q;
      xi_d    = xi_q;
      wr_d    = wr_q;
      wi_d    = wi_q;
      p0_d    = p0_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      p3_d    = p3_q;
      y_re_d  = y_re_q;
      y_im_d  = y_im_q;
      mul_a_o = '0;
      mul_b_o = '0;
      case (state_q)
         S_IDLE: begin
            if (in_valid_i) begin
               xr_d = x_re_i;
               xi_d = x_im_i;
               wr_d = w_re_i;
               wi_d = w_im_i;
               if (w_re_i == W_ONE && w_im_i == '0) begin
                  y_re_d  = fit_out(x_re_i);
                  y_im_d  = fit_out(x_im_i);
                  state_d = S_OUT;
               end else begin
                  state_d = S_P0;
               end
            end
         end
         S_P0: begin
            mul_a_o = xr_q;
            mul_b_o = wr_q;
            p0_d    = mul_p_i;
            state_d = S_P1;
         end
         S_P1: begin
            mul_a_o = xi_q;
            mul_b_o = wi_q;
            p1_d    = mul_p_i;
            state_d = S_P2;
         end
         S_P2: begin
            mul_a_o = xr_q;
            mul_b_o = wi_q;
            p2_d    = mul_p_i;
            state_d = S_P3;
         end
         S_P3: begin
            mul_a_o = xi_q;
            mul_b_o = wr_q;
            p3_d    = mul_p_i;
`ifdef CMUL_SAT_EN
            y_re_d  = reduce(sum_re);
            y_im_d  = reduce(sum_im);
`else
            y_re_d  = sum_re[OUT_W-1:0];
            y_im_d  = sum_im[OUT_W-1:0];
`endif
            state_d = S_OUT;
         end
         S_OUT: begin
            if (out_ready_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         xr_q    <= '0;
         xi_q    <= '0;
         wr_q    <= '0;
         wi_q    <= '0;
         p0_q    <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
         p3_q    <= '0;
         y_re_q  <= '0;
         y_im_q  <= '0;
      end else begin
         state_q <= state_d;
         xr_q    <= xr_d;
         xi_q    <= xi_d;
         wr_q    <= wr_d;
         wi_q    <= wi_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         p3_q    <= p3_d;
         y_re_q  <= y_re_d;
         y_im_q  <= y_im_d;
      end
   end

   assign in_ready_o  = (state_q == S_IDLE);
   assign out_valid_o = (state_q == S_OUT);
   assign busy_o      = (state_q != S_IDLE);
   assign y_re_o      = y_re_q;
   assign y_im_o      = y_im_q;
   assign state_o     = state_q;

endmodule

// File: tb/tb_cmul_sched.sv
// tb_cmul_sched -- self-checking bench for cmul_sched.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// The bench plays the shared multiplier: mul_p = (mul_a*mul_b) >>> FRAC,
// optionally overridden to force overflow of the combined sums.
module tb_cmul_sched;

   localparam int IN_W  = 16;
   localparam int FRAC  = 10;
   localparam int OUT_W = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic signed [IN_W-1:0]  x_re = '0, x_im = '0, w_re = '0, w_im = '0;
   logic signed [IN_W-1:0]  mul_a, mul_b;
   logic signed [OUT_W-1:0] mul_p;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic signed [OUT_W-1:0] y_re, y_im;
   logic                    busy;
   logic [2:0]              state;

   logic                    force_en = 1'b0;
   logic signed [OUT_W-1:0] force_val = '0;

   int checks = 0;
   int failures = 0;
   logic [2*OUT_W-1:0] exp_q[$];
   logic [2*OUT_W-1:0] exp_y;

   cmul_sched #(.IN_W(IN_W), .FRAC(FRAC), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .x_re_i(x_re), .x_im_i(x_im), .w_re_i(w_re), .w_im_i(w_im),
      .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_p_i(mul_p),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .y_re_o(y_re), .y_im_o(y_im), .busy_o(busy), .state_o(state)
   );

   // ---------------- reference model ----------------
   function automatic logic signed [OUT_W-1:0] model_mul(input logic signed [IN_W-1:0] a,
                                                         input logic signed [IN_W-1:0] b);
      int p;
      p = (int'(a) * int'(b)) >>> FRAC;
      return OUT_W'(p);
   endfunction

   function automatic logic signed [OUT_W-1:0] model_reduce(input int s);
`ifdef CMUL_SAT_EN
      if (s > 32767) return 16'sd32767;
      if (s < -32768) return -16'sd32768;
`endif
      return OUT_W'(s);
   endfunction

   function automatic logic [2*OUT_W-1:0] model_y(input logic signed [IN_W-1:0] xr,
                                                  input logic signed [IN_W-1:0] xi,
                                                  input logic signed [IN_W-1:0] wr,
                                                  input logic signed [IN_W-1:0] wi);
      logic signed [OUT_W-1:0] p0, p1, p2, p3;
      if (wr == 16'sd1024 && wi == 16'sd0) return {xr, xi};
      p0 = model_mul(xr, wr);
      p1 = model_mul(xi, wi);
      p2 = model_mul(xr, wi);
      p3 = model_mul(xi, wr);
      return {model_reduce(int'(p0) - int'(p1)), model_reduce(int'(p2) + int'(p3))};
   endfunction

   always_comb mul_p = force_en ? force_val : model_mul(mul_a, mul_b);

   // ---------------- driver tasks ----------------
   task automatic send(input int xr, input int xi, input int wr, input int wi);
      @(negedge clk);
      x_re = IN_W'(xr); x_im = IN_W'(xi); w_re = IN_W'(wr); w_im = IN_W'(wi);
      in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL send_in_ready act=%b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready act=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid act=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy act=%b exp=0", busy); end
      checks++; if (mul_a !== 16'sd0 || mul_b !== 16'sd0) begin failures++; $display("FAIL rst_mul act=%0d,%0d exp=0,0", mul_a, mul_b); end
      checks++; if (y_re !== 16'sd0 || y_im !== 16'sd0) begin failures++; $display("FAIL rst_y act=%0d,%0d exp=0,0", y_re, y_im); end
      rst_n = 1'b1;
   endtask

   task automatic test_normal();
      out_ready = 1'b1;
      exp_q.push_back(model_y(1024, 2048, 0, -1024));
      send(1024, 2048, 0, -1024);
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) @(negedge clk);
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL norm_busy_c%0d act=%b exp=1", c, busy); end
         checks++; if (out_valid !== (c == 5)) begin failures++; $display("FAIL norm_out_valid_c%0d act=%b exp=%b", c, out_valid, (c == 5)); end
      end
      exp_y = exp_q.pop_front();
      checks++; if (y_re !== exp_y[31:16]) begin failures++; $display("FAIL norm_y_re act=%0d exp=%0d", y_re, $signed(exp_y[31:16])); end
      checks++; if (y_im !== exp_y[15:0]) begin failures++; $display("FAIL norm_y_im act=%0d exp=%0d", y_im, $signed(exp_y[15:0])); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL norm_back_idle act=%b%b exp=01", out_valid, in_ready); end
   endtask

   task automatic test_bypass();
      out_ready = 1'b1;
      exp_q.push_back(model_y(-300, 77, 1024, 0));
      send(-300, 77, 1024, 0);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL byp_out_valid act=%b exp=1", out_valid); end
      checks++; if (mul_a !== 16'sd0 || mul_b !== 16'sd0) begin failures++; $display("FAIL byp_mul act=%0d,%0d exp=0,0", mul_a, mul_b); end
      exp_y = exp_q.pop_front();
      checks++; if (y_re !== exp_y[31:16]) begin failures++; $display("FAIL byp_y_re act=%0d exp=%0d", y_re, $signed(exp_y[31:16])); end
      checks++; if (y_im !== exp_y[15:0]) begin failures++; $display("FAIL byp_y_im act=%0d exp=%0d", y_im, $signed(exp_y[15:0])); end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL byp_back_idle act=%b%b exp=01", out_valid, in_ready); end
   endtask

   task automatic test_saturation();
      logic signed [OUT_W-1:0] re_exp;
`ifdef CMUL_SAT_EN
      re_exp = 16'sd32767;
`else
      re_exp = -16'sd1;
`endif
      exp_y = model_y(100, 200, 300, 400);
      exp_q.push_back({re_exp, exp_y[15:0]});
      send(100, 200, 300, 400);
      force_en = 1'b1; force_val = 16'sd32767;
      @(negedge clk);
      force_val = -16'sd32768;
      @(negedge clk);
      force_en = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sat_out_valid act=%b exp=1", out_valid); end
      exp_y = exp_q.pop_front();
      checks++; if (y_re !== exp_y[31:16]) begin failures++; $display("FAIL sat_y_re act=%0d exp=%0d", y_re, $signed(exp_y[31:16])); end
      checks++; if (y_im !== exp_y[15:0]) begin failures++; $display("FAIL sat_y_im act=%0d exp=%0d", y_im, $signed(exp_y[15:0])); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      exp_q.push_back(model_y(500, -700, -800, 900));
      send(500, -700, -800, 900);
      repeat (4) @(negedge clk);
      exp_y = exp_q.pop_front();
      for (int h = 0; h < 10; h++) begin
         checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_h%0d act=%b%b exp=10", h, out_valid, in_ready); end
         checks++; if (y_re !== exp_y[31:16] || y_im !== exp_y[15:0]) begin failures++; $display("FAIL bp_y_h%0d act=%0d,%0d exp=%0d,%0d", h, y_re, y_im, $signed(exp_y[31:16]), $signed(exp_y[15:0])); end
         if (h == 3) begin
            x_re = 16'sd7; x_im = 16'sd8; w_re = 16'sd1024; w_im = 16'sd0; in_valid = 1'b1;
         end
         if (h == 4) in_valid = 1'b0;
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release act=%b%b exp=01", out_valid, in_ready); end
      checks++; if (y_re !== exp_y[31:16] || y_im !== exp_y[15:0]) begin failures++; $display("FAIL bp_y_retained act=%0d,%0d exp=%0d,%0d", y_re, y_im, $signed(exp_y[31:16]), $signed(exp_y[15:0])); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_ignored_c%0d act=%b exp=0", c, out_valid); end
      end
   endtask

   task automatic test_reset_midseq();
      int cnt;
      out_ready = 1'b1;
      send(1000, -500, 700, -300);
      repeat (2) @(negedge clk);
      checks++; if (state !== 3'd3) begin failures++; $display("FAIL mid_in_p2 act=%0d exp=3", state); end
      rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_ctrl act=%b%b%b exp=100", in_ready, out_valid, busy); end
      checks++; if (mul_a !== 16'sd0 || mul_b !== 16'sd0) begin failures++; $display("FAIL mid_rst_mul act=%0d,%0d exp=0,0", mul_a, mul_b); end
      checks++; if (y_re !== 16'sd0 || y_im !== 16'sd0) begin failures++; $display("FAIL mid_rst_y act=%0d,%0d exp=0,0", y_re, y_im); end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model_y(1200, -900, -600, 512));
      send(1200, -900, -600, 512);
      cnt = 1;
      while (!out_valid && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      checks++; if (cnt !== 5) begin failures++; $display("FAIL mid_latency act=%0d exp=5", cnt); end
      exp_y = exp_q.pop_front();
      checks++; if (y_re !== exp_y[31:16] || y_im !== exp_y[15:0]) begin failures++; $display("FAIL mid_y act=%0d,%0d exp=%0d,%0d", y_re, y_im, $signed(exp_y[31:16]), $signed(exp_y[15:0])); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int xr_t[3], xi_t[3], wr_t[3], wi_t[3], acc[3];
      int idx, n_out;
      for (int i = 0; i < 3; i++) begin
         xr_t[i] = int'($urandom_range(0, 8000)) - 4000;
         xi_t[i] = int'($urandom_range(0, 8000)) - 4000;
         wr_t[i] = int'($urandom_range(0, 2000)) - 1000;
         wi_t[i] = int'($urandom_range(0, 2000)) - 1000;
         exp_q.push_back(model_y(16'(xr_t[i]), 16'(xi_t[i]), 16'(wr_t[i]), 16'(wi_t[i])));
         acc[i] = 0;
      end
      out_ready = 1'b1;
      idx = 0;
      n_out = 0;
      for (int cyc = 0; cyc < 60 && n_out < 3; cyc++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            exp_y = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++; if (y_re !== exp_y[31:16] || y_im !== exp_y[15:0]) begin failures++; $display("FAIL b2b_y%0d act=%0d,%0d exp=%0d,%0d", n_out, y_re, y_im, $signed(exp_y[31:16]), $signed(exp_y[15:0])); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_overlap%0d act=%b exp=0", n_out, in_ready); end
            n_out++;
         end
         if (idx < 3) begin
            x_re = IN_W'(xr_t[idx]); x_im = IN_W'(xi_t[idx]);
            w_re = IN_W'(wr_t[idx]); w_im = IN_W'(wi_t[idx]);
            in_valid = 1'b1;
            if (in_ready) begin
               acc[idx] = cyc;
               idx++;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      checks++; if (n_out !== 3) begin failures++; $display("FAIL b2b_outputs act=%0d exp=3", n_out); end
      checks++; if (acc[1] - acc[0] !== 6) begin failures++; $display("FAIL b2b_ii01 act=%0d exp=6", acc[1] - acc[0]); end
      checks++; if (acc[2] - acc[1] !== 6) begin failures++; $display("FAIL b2b_ii12 act=%0d exp=6", acc[2] - acc[1]); end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_normal();
      test_bypass();
      test_saturation();
      test_backpressure();
      test_reset_midseq();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
